stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that shares one downstream stream channel between NUM_REQ free-running producers, each of which presents data with a valid flag. Grants are locked for bursts of up to BURST_LEN beats and then rotated. The block sits between a bank of producers and a single consumer or CDC FIFO write port. It applies valid/ready backpressure upstream and holds registered output data stable while the consumer stalls.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; a power of two, minimum 2.
- DATA_W, 8, beat width in bits.
- BURST_LEN, 4, maximum beats accepted per grant; minimum 1, maximum 255.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- i_Req_Data  in  NUM_REQ*DATA_W  requester r occupies bits [r*DATA_W +: DATA_W].
- i_Req_Valid  in  NUM_REQ  per-requester valid.
- o_Req_Ready  out  NUM_REQ  per-requester ready; combinational.
- o_Output_Data  out  DATA_W  registered output beat.
- o_Data_Valid  out  1  registered output valid.
- i_Out_Ready  in  1  consumer ready.
- o_Grant_Id  out  clog2(NUM_REQ)  requester currently or most recently granted; registered.
- o_Total_Beats  out  16  present only with STREAM_RR_ARB_STATS_EN.

## Operation
- States:
  - IDLE: no grant is held.
  - GRANT: one requester g is locked.
- IDLE, when any i_Req_Valid bit is set:
  - Select the first valid requester, searching upward from rr_ptr with wrap from NUM_REQ-1 to 0.
  - Register it into o_Grant_Id, clear beat_cnt, and enter GRANT.
  - If no valid bit is set, stay in IDLE.
- Readiness:
  - can_load = !o_Data_Valid || i_Out_Ready.
  - o_Req_Ready[g] = (state==GRANT) && can_load.
  - All other o_Req_Ready bits are 0. In IDLE, every bit is 0.
- Accept: i_Req_Valid[g] && o_Req_Ready[g]. On accept:
  - o_Output_Data <= the beat of requester g.
  - o_Data_Valid <= 1.
  - beat_cnt increments.
- Output drain: if can_load holds and there is no accept, o_Data_Valid <= 0.
- Output stall: if o_Data_Valid && !i_Out_Ready, o_Output_Data and o_Data_Valid hold unchanged.
- GRANT exits to IDLE with rr_ptr <= g+1 (mod NUM_REQ) in either case:
  - an accept occurs with beat_cnt == BURST_LEN-1 (the burst is complete);
  - can_load is 1 and i_Req_Valid[g] is 0 (the requester went idle).
- GRANT is held, with no exit, while can_load is 0. A stalled consumer never forces rotation.
- beat_cnt is 8 bits wide. It never exceeds BURST_LEN-1 because the burst-complete exit clears it.
- A requester that drops valid while not ready, then reasserts it before ready, keeps its grant.

## Timing
- Reset values: state IDLE, rr_ptr 0, beat_cnt 0, o_Grant_Id 0, o_Output_Data 0, o_Data_Valid 0, o_Total_Beats 0.
- Reset asserted mid-burst clears everything immediately. Any output beat still held is discarded.
- Arbitration latency is one cycle:
  - A valid request seen in IDLE at edge N is granted after edge N.
  - Its first accept occurs at edge N+1.
  - o_Data_Valid is high after edge N+1.
- Between bursts there is one IDLE bubble cycle. Worst-case throughput is BURST_LEN/(BURST_LEN+1).
- Within a burst with i_Out_Ready held high, throughput is one beat per cycle.
- o_Req_Ready depends combinationally on i_Out_Ready. No other path is combinational.

## Configuration
- STREAM_RR_ARB_STATS_EN defined:
  - Adds the o_Total_Beats port.
  - The counter increments on every output handshake (o_Data_Valid && i_Out_Ready).
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- Single requester: only requester 2 valid, with counting data 0,1,2,… and i_Out_Ready high.
  - Grant goes to 2; output carries bursts of 4 beats separated by a one-cycle gap.
  - No beat is lost or duplicated.
- All four requesters valid, with distinct data A,B,C,D and i_Out_Ready high.
  - Grants run 0,1,2,3,0,…, each 4 beats long.
  - The output sequence is AAAA BBBB CCCC DDDD.
- Backpressure: i_Out_Ready low for 5 cycles during beat 2 of a burst.
  - o_Output_Data holds stable and o_Data_Valid stays 1.
  - o_Req_Ready[g] stays 0 and the grant does not rotate.
  - The burst resumes at beat 3.
- Early drop: requester 1 deasserts valid after 2 beats.
  - The FSM returns to IDLE and rr_ptr becomes 2.
  - Requester 2 is granted next, even though requester 0 is also valid.
- Reset mid-burst: assert resetn=0 during beat 3.
  - All outputs go to their reset values immediately.
  - After release, the first grant goes to the lowest valid requester, since rr_ptr is 0.
- STREAM_RR_ARB_STATS_EN: after 20 output handshakes, o_Total_Beats reads 20.
  - With the counter forced near its limit, it saturates at 65535.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one downstream valid/ready stream between
//   NUM_REQ free-running producers. A grant stays locked for a burst of up to
//   BURST_LEN beats. The grant then rotates to the next requester. The output
//   beat is registered and holds stable while the consumer stalls.
//
// Optional feature macro:
//   STREAM_RR_ARB_STATS_EN - adds o_Total_Beats, a saturating 16-bit count of
//                            output handshakes. When the macro is undefined,
//                            the port and the counter are absent.
//
// Parameters:
//   NUM_REQ   - number of requesters (power of two, >= 2)
//   DATA_W    - beat width in bits
//   BURST_LEN - maximum beats accepted per grant (1..255)
//
// Ports:
//   clk           in   clock
//   resetn        in   asynchronous active-low reset
//   i_Req_Data    in   packed requester beats, requester r at [r*DATA_W +: DATA_W]
//   i_Req_Valid   in   per-requester valid
//   o_Req_Ready   out  per-requester ready (combinational, depends on i_Out_Ready)
//   o_Output_Data out  registered output beat
//   o_Data_Valid  out  registered output valid
//   i_Out_Ready   in   consumer ready
//   o_Grant_Id    out  requester currently or most recently granted (registered)
//   o_Total_Beats out  output handshake count (only with STREAM_RR_ARB_STATS_EN)
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ*DATA_W-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]        i_Req_Valid,
  output logic [NUM_REQ-1:0]        o_Req_Ready,
  output logic [DATA_W-1:0]         o_Output_Data,
  output logic                      o_Data_Valid,
  input  logic                      i_Out_Ready,
  output logic [ID_W-1:0]           o_Grant_Id
`ifdef STREAM_RR_ARB_STATS_EN
  ,
  output logic [15:0]               o_Total_Beats
`endif
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     grant_q;
  logic [7:0]          beat_cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;

  logic                can_load;
  logic                in_grant;
  logic                accept;
  logic                burst_last;
  logic [DATA_W-1:0]   grant_data;
  logic [NUM_REQ-1:0]  rot_valid;
  logic [ID_W-1:0]     sel_off_d;
  logic [ID_W-1:0]     sel_id_d;
  logic [ID_W-1:0]     next_ptr_d;

  // The output register may take a new beat when it is empty or is being
  // drained by the consumer in this same cycle.
  assign can_load   = !valid_q || i_Out_Ready;
  assign in_grant   = (state_q == S_GRANT);
  assign grant_data = i_Req_Data[grant_q*DATA_W +: DATA_W];
  assign accept     = in_grant && can_load && i_Req_Valid[grant_q];
  assign burst_last = (beat_cnt_q == 8'(BURST_LEN - 1));
  assign next_ptr_d = grant_q + ID_W'(1);

  // Rotate the valid vector so that bit 0 corresponds to rr_ptr. A plain
  // lowest-bit priority search then implements the wrapping round-robin
  // search. NUM_REQ is a power of two, so the index wraps by truncation.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [ID_W-1:0] src_idx;
    assign src_idx       = rr_ptr_q + ID_W'(gi);
    assign rot_valid[gi] = i_Req_Valid[src_idx];
  end

  always_comb begin
    sel_off_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        sel_off_d = ID_W'(k);
      end
    end
  end

  assign sel_id_d = rr_ptr_q + sel_off_d;

  // Only the locked requester can ever see ready, and only in GRANT.
  always_comb begin
    o_Req_Ready = '0;
    if (in_grant && can_load) begin
      o_Req_Ready[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      // Output register. It loads on accept, drains when free, and otherwise
      // holds while the consumer stalls.
      if (accept) begin
        data_q  <= grant_data;
        valid_q <= 1'b1;
      end else if (can_load) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (|i_Req_Valid) begin
            grant_q    <= sel_id_d;
            beat_cnt_q <= '0;
            state_q    <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (accept) begin
            if (burst_last) begin
              state_q    <= S_IDLE;
              rr_ptr_q   <= next_ptr_d;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end else if (can_load && !i_Req_Valid[grant_q]) begin
            // The requester went idle while it could have been served.
            // A valid drop while stalled (can_load low) is ignored, so a
            // requester that reasserts before ready keeps its grant.
            state_q  <= S_IDLE;
            rr_ptr_q <= next_ptr_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Output_Data = data_q;
  assign o_Data_Valid  = valid_q;
  assign o_Grant_Id    = grant_q;

`ifdef STREAM_RR_ARB_STATS_EN
  logic [15:0] total_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      total_q <= '0;
    end else if (valid_q && i_Out_Ready && (total_q != 16'hFFFF)) begin
      total_q <= total_q + 16'd1;
    end
  end

  assign o_Total_Beats = total_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Directed bench for stream_rr_arbiter (NUM_REQ=4, DATA_W=8, BURST_LEN=4).
// Expected output beats {grant id, data} are queued when a scenario is set up.
// They are popped on each output handshake and compared.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          clk;
  logic          resetn;
  logic [NR*DW-1:0] i_Req_Data;
  logic [NR-1:0] i_Req_Valid;
  logic [NR-1:0] o_Req_Ready;
  logic [DW-1:0] o_Output_Data;
  logic          o_Data_Valid;
  logic          i_Out_Ready;
  logic [1:0]    o_Grant_Id;
`ifdef STREAM_RR_ARB_STATS_EN
  logic [15:0]   o_Total_Beats;
`endif

  stream_rr_arbiter #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .BURST_LEN(4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_Req_Data   (i_Req_Data),
    .i_Req_Valid  (i_Req_Valid),
    .o_Req_Ready  (o_Req_Ready),
    .o_Output_Data(o_Output_Data),
    .o_Data_Valid (o_Data_Valid),
    .i_Out_Ready  (i_Out_Ready),
    .o_Grant_Id   (o_Grant_Id)
`ifdef STREAM_RR_ARB_STATS_EN
    ,
    .o_Total_Beats(o_Total_Beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];
  logic [7:0]  pdata[NR];
  int          acc_cnt[NR];
  bit          count_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int id, input logic [7:0] d);
    return {8'(id), d};
  endfunction

  task automatic pack();
    for (int r = 0; r < NR; r++) i_Req_Data[r*DW +: DW] = pdata[r];
  endtask

  // Entered at a falling edge with inputs already driven. It samples and
  // checks the output handshake, crosses the rising edge, and returns at the
  // next falling edge after advancing producer data for accepted beats.
  task automatic tick();
    logic [NR-1:0] acc;
    logic [15:0]   exp_v;
    pack();
    #1;
    acc = i_Req_Valid & o_Req_Ready;
    if (o_Data_Valid && i_Out_Ready) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", {8'(o_Grant_Id), o_Output_Data});
      end
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        chk("out_beat", {8'(o_Grant_Id), o_Output_Data}, exp_v);
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      if (acc[r]) begin
        acc_cnt[r]++;
        if (count_en) pdata[r] = pdata[r] + 8'd1;
      end
    end
    pack();
  endtask

  task automatic run_until_empty(input string tag, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    i_Req_Valid = '0;
    i_Out_Ready = 1'b1;
    sb.delete();
    for (int r = 0; r < NR; r++) begin
      acc_cnt[r] = 0;
      pdata[r]   = '0;
    end
    pack();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_Data_Valid, 0);
    chk("rst_data", o_Output_Data, 0);
    chk("rst_grant", o_Grant_Id, 0);
    chk("rst_ready", o_Req_Ready, 0);
`ifdef STREAM_RR_ARB_STATS_EN
    chk("rst_total", o_Total_Beats, 0);
`endif
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    resetn      = 1'b0;
    i_Req_Valid = '0;
    i_Out_Ready = 1'b1;
    i_Req_Data  = '0;
    count_en    = 1'b1;
    @(negedge clk);

    // ---- single requester 2, counting data, bursts of 4 with a 1-cycle gap
    do_reset();
    count_en       = 1'b1;
    pdata[2]       = 8'd0;
    i_Req_Valid    = 4'b0100;
    pack();
    #1;
    chk("idle_ready", o_Req_Ready, 0);
    for (int i = 0; i < 12; i++) sb.push_back(mk(2, 8'(i)));
    tick();
    chk("t1_grant", o_Grant_Id, 2);
    chk("t1_ready", o_Req_Ready, 4'b0100);
    chk("t1_valid_lat", o_Data_Valid, 0);
    tick();
    chk("t1_first_valid", o_Data_Valid, 1);
    chk("t1_first_data", o_Output_Data, 0);
    for (int k = 0; k < 14; k++) begin
      chk("t1_valid_pattern", o_Data_Valid, (k % 5) != 4);
      tick();
    end
    chk("t1_sb_empty", sb.size(), 0);

    // ---- all four valid, constant data, grants 0,1,2,3,0
    do_reset();
    count_en = 1'b0;
    for (int r = 0; r < NR; r++) pdata[r] = 8'hAA + 8'(8'h11 * r);
    i_Req_Valid = 4'b1111;
    for (int b = 0; b < 5; b++)
      for (int j = 0; j < 4; j++) sb.push_back(mk(b % 4, 8'hAA + 8'(8'h11 * (b % 4))));
    run_until_empty("t2_done", 60);
`ifdef STREAM_RR_ARB_STATS_EN
    chk("t2_total_beats", o_Total_Beats, 20);
`endif

    // ---- backpressure during beat 2 of a burst from requester 0
    do_reset();
    count_en    = 1'b1;
    pdata[0]    = 8'h40;
    i_Req_Valid = 4'b0001;
    for (int i = 0; i < 8; i++) sb.push_back(mk(0, 8'h40 + 8'(i)));
    n = 0;
    while (!(o_Data_Valid && o_Output_Data == 8'h42) && n < 20) begin
      tick();
      n++;
    end
    chk("t3_reach_beat2", n < 20, 1);
    i_Out_Ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t3_stall_data", o_Output_Data, 8'h42);
      chk("t3_stall_valid", o_Data_Valid, 1);
      chk("t3_stall_ready", o_Req_Ready, 0);
      chk("t3_stall_grant", o_Grant_Id, 0);
    end
    i_Out_Ready = 1'b1;
    run_until_empty("t3_done", 30);

    // ---- early drop by requester 1 after two beats; requester 2 is next
    do_reset();
    count_en    = 1'b1;
    pdata[0]    = 8'h70;
    pdata[1]    = 8'h50;
    pdata[2]    = 8'h60;
    i_Req_Valid = 4'b0010;
    sb.push_back(mk(1, 8'h50));
    sb.push_back(mk(1, 8'h51));
    for (int i = 0; i < 4; i++) sb.push_back(mk(2, 8'h60 + 8'(i)));
    tick();
    chk("t4_grant1", o_Grant_Id, 1);
    i_Req_Valid = 4'b0111;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      if (acc_cnt[1] == 2) i_Req_Valid[1] = 1'b0;
      tick();
      n++;
    end
    chk("t4_done", sb.size(), 0);

    // ---- reset during a burst from requester 3 (rr_ptr is 3 at that point)
    do_reset();
    count_en    = 1'b1;
    pdata[2]    = 8'h20;
    pdata[3]    = 8'h30;
    i_Req_Valid = 4'b1100;
    for (int i = 0; i < 4; i++) sb.push_back(mk(2, 8'h20 + 8'(i)));
    sb.push_back(mk(3, 8'h30));
    sb.push_back(mk(3, 8'h31));
    run_until_empty("t5_prefix", 40);
    chk("t5_mid_data", o_Output_Data, 8'h32);
    chk("t5_mid_grant", o_Grant_Id, 3);
    #1;
    resetn = 1'b0;
    #1;
    chk("t5_async_valid", o_Data_Valid, 0);
    chk("t5_async_data", o_Output_Data, 0);
    chk("t5_async_grant", o_Grant_Id, 0);
    chk("t5_async_ready", o_Req_Ready, 0);
    sb.delete();
    pdata[1]    = 8'h11;
    i_Req_Valid = 4'b1010;
    pack();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("t5_post_grant", o_Grant_Id, 1);
    chk("t5_post_ready", o_Req_Ready, 4'b0010);
    tick();
    chk("t5_post_valid", o_Data_Valid, 1);
    chk("t5_post_data", o_Output_Data, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
